// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: slice width and a
// one-bit carry/sum built from two half adders.
package adder_pkg;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder: returns {cout, sum}
    function automatic logic [1:0] carry_sum(input logic a, input logic b,
                                             input logic c);
        logic [1:0] h0;
        logic [1:0] h1;
        h0 = half_add(a, b);
        h1 = half_add(h0[0], c);
        return {h0[1] | h1[1], h1[0]};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple adder built from a chain of full adders.
module adder_slice
    import adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign {c[i+1], s[i]} = carry_sum(a[i], b[i], c[i]);
    end

    assign cout = c[W];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder, one slice per stage, valid/ready stall.
// Define ADD_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int SL = slice_w(WIDTH, STAGES);

    logic                       adv;
    logic                       take;
    logic [STAGES-1:0]          v;
    logic [STAGES-1:0]          cin_s;
    logic [STAGES-1:0]          cy_d;
    logic [STAGES-1:0]          cy_q;
    logic [STAGES-1:0][SL-1:0]  op_a;
    logic [STAGES-1:0][SL-1:0]  op_b;
    logic [STAGES-1:0][SL-1:0]  sres;

    assign out_valid = v[STAGES-1];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign take      = in_valid && adv;
    assign cout      = cy_q[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v    <= '0;
            cy_q <= '0;
        end else if (adv) begin
            v[0] <= take;
            for (int k = 1; k < STAGES; k++) begin
                v[k] <= v[k-1];
            end
            cy_q <= cy_d;
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_slice
        localparam int D = STAGES - j;

        logic [SL-1:0] dsk [D];

        if (j == 0) begin : g_in
            assign op_a[0]  = a[SL-1:0];
            assign op_b[0]  = b[SL-1:0];
            assign cin_s[0] = cin;
        end else begin : g_skew
            // Slice j waits j stages for the carry from below
            logic [SL-1:0] ska [j];
            logic [SL-1:0] skb [j];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int d = 0; d < j; d++) begin
                        ska[d] <= '0;
                        skb[d] <= '0;
                    end
                end else if (adv) begin
                    ska[0] <= a[j*SL +: SL];
                    skb[0] <= b[j*SL +: SL];
                    for (int d = 1; d < j; d++) begin
                        ska[d] <= ska[d-1];
                        skb[d] <= skb[d-1];
                    end
                end
            end

            assign op_a[j]  = ska[j-1];
            assign op_b[j]  = skb[j-1];
            assign cin_s[j] = cy_q[j-1];
        end

        adder_slice #(.W(SL)) u_add (
            .a    (op_a[j]),
            .b    (op_b[j]),
            .cin  (cin_s[j]),
            .s    (sres[j]),
            .cout (cy_d[j])
        );

        // Finished slices ride along until the top slice catches up
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int d = 0; d < D; d++) begin
                    dsk[d] <= '0;
                end
            end else if (adv) begin
                dsk[0] <= sres[j];
                for (int d = 1; d < D; d++) begin
                    dsk[d] <= dsk[d-1];
                end
            end
        end

        assign sum[j*SL +: SL] = dsk[D-1];
    end

`ifdef ADD_OVF_EN
    // Top slice operands still carry the sign bits at the last stage
    logic ovf_d;
    logic ovf_q;

    always_comb begin
        ovf_d = (op_a[STAGES-1][SL-1] == op_b[STAGES-1][SL-1]) &&
                (sres[STAGES-1][SL-1] != op_a[STAGES-1][SL-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2).
// Builds with or without ADD_OVF_EN.
module tb_pipelined_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
`ifdef ADD_OVF_EN
    logic       ovf;
`endif

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    int   first_cyc  = -1;
    int   last_cyc   = -1;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef ADD_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Drive at negedge; accepted if in_ready is high before the next posedge
    task automatic send(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es,
                        input logic ec, input logic eo, input int tag);
        bit ok;
        int tries;
        exp_t e;
        ok = 0;
        tries = 0;
        while (!ok) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = ta;
            b = tb;
            cin = tc;
            #1;
            ok = in_ready;
            @(posedge clk);
            if (ok) begin
                e.sum = es;
                e.cout = ec;
                e.ovf = eo;
                e.tag = tag;
                q.push_back(e);
            end else if (++tries > 50) begin
                mismatched++;
                $display("FAIL send_timeout: in_ready stuck 0 for a=%0h", ta);
                ok = 1;
            end
        end
    endtask

    task automatic send_gold(input logic [7:0] ta, input logic [7:0] tb,
                             input logic tc, input int tag);
        logic [8:0] r;
        logic       o;
        r = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
        o = (ta[7] == tb[7]) && (r[7] != ta[7]);
        send(ta, tb, tc, r[7:0], r[8], o, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: %0d results still pending", q.size());
            q.delete();
        end
    endtask

    // Monitor: a handshake occurs at the next posedge when both are high
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out: sum=%0h cout=%0b with nothing pending",
                             sum, cout);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("out_sum[tag%0d]", e.tag), 32'(sum), 32'(e.sum));
                    chk($sformatf("out_cout[tag%0d]", e.tag), 32'(cout), 32'(e.cout));
`ifdef ADD_OVF_EN
                    chk($sformatf("out_ovf[tag%0d]", e.tag), 32'(ovf), 32'(e.ovf));
`endif
                    if (e.tag == 100) first_cyc = cyc;
                    if (e.tag == 115) last_cyc = cyc;
                end
            end
        end
    end

    logic [7:0] ba [16];
    logic [7:0] bb [16];
    logic       bc [16];
    logic [7:0] held_sum;
    logic       held_cout;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;

        ba = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h12, 8'hA5, 8'h5A, 8'hC3,
               8'h01, 8'hFE, 8'h99, 8'h66, 8'hF0, 8'h0F, 8'h3C, 8'hE7};
        bb = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h34, 8'h5A, 8'hA5, 8'h3C,
               8'hFF, 8'h01, 8'h99, 8'h66, 8'h0F, 8'hF0, 8'hC3, 8'h18};
        bc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset with two transactions in flight
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1);
        send(8'h44, 8'h55, 1'b0, 8'h99, 1'b0, 1'b1, 2);
        #1;
        chk("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(6);

        // Directed vectors with hand-computed results
        send(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 10);
        send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 11);
        send(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 12);
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 13);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 14);
        idle(1);
        drain();

        // Back-to-back burst, one result per cycle expected
        for (int i = 0; i < 16; i++) begin
            send_gold(ba[i], bb[i], bc[i], 100 + i);
        end
        idle(1);
        drain();
        chk("burst_span", 32'(last_cyc - first_cyc), 32'd15);

        // Back-pressure with the pipe full
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h21, 8'h43, 1'b1, 8'h65, 1'b0, 1'b0, 200);
        send(8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 201);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        held_sum = sum;
        held_cout = cout;
        chk("bp_first_sum", 32'(held_sum), 32'h65);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_in_ready[%0d]", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp_sum_hold[%0d]", i), 32'(sum), 32'(held_sum));
            chk($sformatf("bp_cout_hold[%0d]", i), 32'(cout), 32'(held_cout));
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        idle(4);
        chk("final_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule
